multicycle_main_fsm: RTL and testbench
======================================

# multicycle_main_fsm

Sequencing controller for the multicycle ARM datapath, replacing the single-cycle main decoder. It:
- walks each instruction through fetch, decode, execute, memory and writeback states;
- stalls on a memory ready handshake;
- suppresses instructions whose condition fails;
- counts retired instructions;
- enters a sticky fault state when memory never answers.

It sits in the controller between the instruction register fields and the datapath enables. The ALU decoder and condition logic stay separate blocks.

## Interface
- WAIT_LIMIT, 15: maximum consecutive cycles a memory state waits for `mem_ready` before faulting (1..255).
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- op  in  2  instruction bits [27:26]; 00 DP, 01 memory, 10 branch, 11 undefined.
- funct_5  in  1  instruction bit 25 (immediate operand).
- funct_0  in  1  instruction bit 20 (L for memory, S for DP).
- cond_ex  in  1  condition-passed flag from the condition unit, valid in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- ir_w  out  1  instruction register write enable.
- next_pc  out  1  PC write enable.
- reg_w, mem_w, branch, alu_op  out  1 each  datapath enables.
- adr_src, alu_src_a  out  1 each  mux selects.
- alu_src_b, result_src  out  2 each  mux selects.
- imm_src  out  2  DP 00, memory 01, branch 10, undefined 00.
- reg_src  out  3  encoding as in the single-cycle decoder; DP reg 100, DP imm 000, STR 010, LDR 000, B 001.
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.
- fault  out  1  sticky memory-timeout flag.

## Operation
Outputs are Moore-decoded from the state, except for the ready gating described below. Any select or enable not listed for a state is 0.

States and outputs:
- FETCH: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10. ir_w and next_pc equal mem_ready.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10.
- MEMADR: alu_src_a=0, alu_src_b=01.
- MEMREAD: mem_req=1, adr_src=1, result_src=00.
- MEMWB: result_src=01, reg_w=1.
- MEMWRITE: mem_req=1, adr_src=1, result_src=00. mem_w equals mem_ready.
- EXECUTER: alu_src_a=0, alu_src_b=00, alu_op=1.
- EXECUTEI: alu_src_a=0, alu_src_b=01, alu_op=1.
- ALUWB: result_src=00, reg_w=1.
- BRANCH: alu_src_a=0, alu_src_b=01, result_src=10, branch=1.
- FAULT: all enables 0, fault=1.

`imm_src` and `reg_src` are combinational functions of `op`, `funct_5` and `funct_0` in every state.

Transitions:
- FETCH → DECODE when mem_ready=1; otherwise stay.
- DECODE branches as follows:
  - cond_ex=0 → FETCH (instruction skipped; the PC was already advanced).
  - op=00 → EXECUTEI if funct_5=1, else EXECUTER.
  - op=01 → MEMADR.
  - op=10 → BRANCH.
  - op=11 → FETCH (treated as NOP).
- MEMADR → MEMREAD if funct_0=1, else MEMWRITE.
- MEMREAD → MEMWB on mem_ready=1.
- MEMWRITE → FETCH on mem_ready=1.
- MEMWB, ALUWB and BRANCH → FETCH.
- EXECUTER and EXECUTEI → ALUWB.
- FAULT → FAULT until reset.

Retire rules:
- `instr_count` increments by 1 on the cycle that leaves:
  - DECODE toward FETCH (skipped or undefined instruction);
  - MEMWB, MEMWRITE (on ready), ALUWB or BRANCH.
- At most one increment per instruction.

Wait counter:
- Resets to 0 whenever the state changes.
- Increments on each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
- If it equals WAIT_LIMIT while mem_ready=0, the next state is FAULT. mem_ready=1 in the same cycle wins and completes the access.

## Timing
- Reset (reset_n low, asynchronous):
  - state=FETCH, wait counter=0, instr_count=0, fault=0.
  - Outputs are immediately the FETCH decode with mem_ready gating: mem_req=1, and ir_w = next_pc = mem_ready.
- Releasing reset mid-instruction restarts at FETCH; no partial writeback occurs.
- ir_w, next_pc and mem_w assert for exactly one cycle per access: the cycle in which mem_ready=1.
- Minimum latencies with zero wait cycles:
  - DP: 4 cycles (FETCH, DECODE, EXECUTE, ALUWB).
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Skipped instruction: 2 cycles.
- Each wait cycle adds 1 to the instruction's latency.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- instr_count wrap: at all-ones, the next retire gives 0.

## Test plan
- Reset with mem_ready=1, then DP reg (op=00, funct_5=0, cond_ex=1) → 4-cycle sequence: FETCH, DECODE, EXECUTER, ALUWB. ALUWB shows reg_w=1, reg_src=100. instr_count=1.
- LDR (op=01, funct_0=1) with mem_ready held low 3 cycles in MEMREAD → MEMWB reached after 8 cycles total; reg_w=1, result_src=01 in MEMWB. ir_w pulses exactly once.
- STR then B → mem_w=1 for one cycle, reg_src=010 during STR. B shows branch=1, imm_src=10, reg_src=001. instr_count=2 after 7 cycles.
- cond_ex=0 at DECODE for a DP instruction → returns to FETCH with no reg_w assertion; instr_count increments.
- WAIT_LIMIT=3 with mem_ready stuck low in FETCH → fault=1 from the 5th cycle after reset, stays 1. Reset clears fault and returns to FETCH.
- CNT_W=4, 17 B instructions → instr_count reads 1.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle ARM datapath: sequences each instruction through its
// states, stalls on the memory ready handshake, counts retirements and traps memory timeouts.
module multicycle_main_fsm #(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       op,
   input  logic             funct_5,
   input  logic             funct_0,
   input  logic             cond_ex,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             ir_w,
   output logic             next_pc,
   output logic             reg_w,
   output logic             mem_w,
   output logic             branch,
   output logic             alu_op,
   output logic             adr_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       result_src,
   output logic [1:0]       imm_src,
   output logic [2:0]       reg_src,
   output logic [CNT_W-1:0] instr_count,
   output logic             fault
);

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
      StExecR, StExecI, StAluWb, StBranch, StFault
   } state_e;

   localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

   state_e           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] count_q;
   logic             retire;
   logic             mem_state;
   logic             timed_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFetch;
         wait_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (retire) count_q <= count_q + CNT_W'(1);
      end
   end

   assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
   // A ready in the limit cycle still completes the access.
   assign timed_out = !mem_ready && (wait_q == WaitLimit);

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      unique case (state_q)
         StFetch: begin
            if (mem_ready)      state_d = StDecode;
            else if (timed_out) state_d = StFault;
         end
         StDecode: begin
            if (!cond_ex) begin
               state_d = StFetch;
               retire  = 1'b1;
            end else begin
               unique case (op)
                  2'b00: state_d = funct_5 ? StExecI : StExecR;
                  2'b01: state_d = StMemAdr;
                  2'b10: state_d = StBranch;
                  2'b11: begin
                     state_d = StFetch;
                     retire  = 1'b1;
                  end
                  default: state_d = StFetch;
               endcase
            end
         end
         StMemAdr: state_d = funct_0 ? StMemRead : StMemWrite;
         StMemRead: begin
            if (mem_ready)      state_d = StMemWb;
            else if (timed_out) state_d = StFault;
         end
         StMemWrite: begin
            if (mem_ready) begin
               state_d = StFetch;
               retire  = 1'b1;
            end else if (timed_out) begin
               state_d = StFault;
            end
         end
         StMemWb, StAluWb, StBranch: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StExecR, StExecI: state_d = StAluWb;
         StFault:          state_d = StFault;
         default:          state_d = StFetch;
      endcase
   end

   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q)           wait_d = '0;
      else if (mem_state && !mem_ready) wait_d = wait_q + 8'd1;
   end

   always_comb begin
      mem_req    = 1'b0;
      ir_w       = 1'b0;
      next_pc    = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      branch     = 1'b0;
      alu_op     = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      fault      = 1'b0;
      unique case (state_q)
         StFetch: begin
            mem_req    = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_w       = mem_ready;
            next_pc    = mem_ready;
         end
         StDecode: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         StMemAdr: alu_src_b = 2'b01;
         StMemRead: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         StMemWb: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         StMemWrite: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            mem_w   = mem_ready;
         end
         StExecR: alu_op = 1'b1;
         StExecI: begin
            alu_src_b = 2'b01;
            alu_op    = 1'b1;
         end
         StAluWb: reg_w = 1'b1;
         StBranch: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
         end
         StFault: fault = 1'b1;
         default: ;
      endcase
   end

   // Immediate and register-source selects follow the IR fields in every state.
   always_comb begin
      imm_src = 2'b00;
      reg_src = 3'b000;
      unique case (op)
         2'b00: reg_src = funct_5 ? 3'b000 : 3'b100;
         2'b01: begin
            imm_src = 2'b01;
            reg_src = funct_0 ? 3'b000 : 3'b010;
         end
         2'b10: begin
            imm_src = 2'b10;
            reg_src = 3'b001;
         end
         default: ;
      endcase
   end

   assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized and directed checks of multicycle_main_fsm against an instruction-level schedule
// model; a second instance with WAIT_LIMIT=3, CNT_W=4 covers timeout and counter wrap.
module tb_multicycle_main_fsm;

   typedef enum int {PF, PD, PMA, PMR, PMWB, PMW, PER, PEI, PAWB, PB, PFLT} phase_t;
   typedef struct {
      phase_t     ph;
      logic       rdy;
      logic       cx;
      logic [1:0] o;
      logic       f5;
      logic       f0;
      bit         retire;
   } entry_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] op = 2'b00;
   logic       funct_5 = 1'b0, funct_0 = 1'b0, cond_ex = 1'b0, mem_ready = 1'b0;

   logic m_mem_req, m_ir_w, m_next_pc, m_reg_w, m_mem_w, m_branch, m_alu_op, m_adr_src;
   logic m_alu_src_a, m_fault;
   logic [1:0] m_alu_src_b, m_result_src, m_imm_src;
   logic [2:0] m_reg_src;
   logic [31:0] m_instr_count;

   logic a_mem_req, a_ir_w, a_next_pc, a_reg_w, a_mem_w, a_branch, a_alu_op, a_adr_src;
   logic a_alu_src_a, a_fault;
   logic [1:0] a_alu_src_b, a_result_src, a_imm_src;
   logic [2:0] a_reg_src;
   logic [3:0] a_instr_count;

   logic [18:0] obs_m, obs_a;
   assign obs_m = {m_mem_req, m_ir_w, m_next_pc, m_reg_w, m_mem_w, m_branch, m_alu_op,
                   m_adr_src, m_alu_src_a, m_alu_src_b, m_result_src, m_imm_src, m_reg_src,
                   m_fault};
   assign obs_a = {a_mem_req, a_ir_w, a_next_pc, a_reg_w, a_mem_w, a_branch, a_alu_op,
                   a_adr_src, a_alu_src_a, a_alu_src_b, a_result_src, a_imm_src, a_reg_src,
                   a_fault};

   multicycle_main_fsm u_main (
      .clk(clk), .reset_n(reset_n), .op(op), .funct_5(funct_5), .funct_0(funct_0),
      .cond_ex(cond_ex), .mem_ready(mem_ready), .mem_req(m_mem_req), .ir_w(m_ir_w),
      .next_pc(m_next_pc), .reg_w(m_reg_w), .mem_w(m_mem_w), .branch(m_branch),
      .alu_op(m_alu_op), .adr_src(m_adr_src), .alu_src_a(m_alu_src_a),
      .alu_src_b(m_alu_src_b), .result_src(m_result_src), .imm_src(m_imm_src),
      .reg_src(m_reg_src), .instr_count(m_instr_count), .fault(m_fault)
   );

   multicycle_main_fsm #(.WAIT_LIMIT(3), .CNT_W(4)) u_aux (
      .clk(clk), .reset_n(reset_n), .op(op), .funct_5(funct_5), .funct_0(funct_0),
      .cond_ex(cond_ex), .mem_ready(mem_ready), .mem_req(a_mem_req), .ir_w(a_ir_w),
      .next_pc(a_next_pc), .reg_w(a_reg_w), .mem_w(a_mem_w), .branch(a_branch),
      .alu_op(a_alu_op), .adr_src(a_adr_src), .alu_src_a(a_alu_src_a),
      .alu_src_b(a_alu_src_b), .result_src(a_result_src), .imm_src(a_imm_src),
      .reg_src(a_reg_src), .instr_count(a_instr_count), .fault(a_fault)
   );

   always #5 clk = ~clk;

   entry_t sched[$];
   int vectors = 0;
   int miscompares = 0;
   int cnt_m = 0;
   int cnt_a = 0;

   // Expected outputs for one cycle, straight from the per-state output table.
   function automatic logic [18:0] exp_vec(entry_t e);
      logic mreq, irw, npc, rw, mw, br, aop, adr, asa, flt;
      logic [1:0] asb, rs, imm;
      logic [2:0] rsrc;
      {mreq, irw, npc, rw, mw, br, aop, adr, asa, flt} = '0;
      asb = 2'b00;
      rs  = 2'b00;
      case (e.ph)
         PF:   begin mreq = 1; asa = 1; asb = 2'b10; rs = 2'b10; irw = e.rdy; npc = e.rdy; end
         PD:   begin asa = 1; asb = 2'b10; rs = 2'b10; end
         PMA:  asb = 2'b01;
         PMR:  begin mreq = 1; adr = 1; end
         PMWB: begin rs = 2'b01; rw = 1; end
         PMW:  begin mreq = 1; adr = 1; mw = e.rdy; end
         PER:  aop = 1;
         PEI:  begin asb = 2'b01; aop = 1; end
         PAWB: rw = 1;
         PB:   begin asb = 2'b01; rs = 2'b10; br = 1; end
         PFLT: flt = 1;
         default: ;
      endcase
      imm  = (e.o == 2'b01) ? 2'b01 : (e.o == 2'b10) ? 2'b10 : 2'b00;
      rsrc = (e.o == 2'b00) ? (e.f5 ? 3'b000 : 3'b100) :
             (e.o == 2'b01) ? (e.f0 ? 3'b000 : 3'b010) :
             (e.o == 2'b10) ? 3'b001 : 3'b000;
      return {mreq, irw, npc, rw, mw, br, aop, adr, asa, asb, rs, imm, rsrc, flt};
   endfunction

   function automatic void push(phase_t p, logic rdy, logic cx, logic [1:0] o, logic f5,
                                logic f0, bit ret);
      entry_t e;
      e.ph = p; e.rdy = rdy; e.cx = cx; e.o = o; e.f5 = f5; e.f0 = f0; e.retire = ret;
      sched.push_back(e);
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   // Appends the cycle schedule of one instruction; wf/wm are the not-ready cycles before
   // memory answers in fetch / data access. Waiting past the limit ends in the fault state.
   function automatic void build(int limit, logic [1:0] o, logic f5, logic f0, logic cond,
                                 int wf, int wm);
      phase_t acc;
      for (int i = 0; i < wf && i <= limit; i++) push(PF, 1'b0, rb(), o, f5, f0, 0);
      if (wf > limit) begin
         push(PFLT, rb(), rb(), o, f5, f0, 0);
         return;
      end
      push(PF, 1'b1, rb(), o, f5, f0, 0);
      if (!cond || o == 2'b11) begin
         push(PD, rb(), cond, o, f5, f0, 1);
         return;
      end
      push(PD, rb(), 1'b1, o, f5, f0, 0);
      if (o == 2'b00) begin
         push(f5 ? PEI : PER, rb(), rb(), o, f5, f0, 0);
         push(PAWB, rb(), rb(), o, f5, f0, 1);
      end else if (o == 2'b01) begin
         acc = f0 ? PMR : PMW;
         push(PMA, rb(), rb(), o, f5, f0, 0);
         for (int i = 0; i < wm && i <= limit; i++) push(acc, 1'b0, rb(), o, f5, f0, 0);
         if (wm > limit) begin
            push(PFLT, rb(), rb(), o, f5, f0, 0);
            return;
         end
         push(acc, 1'b1, rb(), o, f5, f0, !f0);
         if (f0) push(PMWB, rb(), rb(), o, f5, f0, 1);
      end else begin
         push(PB, rb(), rb(), o, f5, f0, 1);
      end
   endfunction

   task automatic apply(input entry_t e);
      @(negedge clk);
      op = e.o; funct_5 = e.f5; funct_0 = e.f0; cond_ex = e.cx; mem_ready = e.rdy;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      cnt_m = 0;
      cnt_a = 0;
      sched.delete();
   endtask

   task automatic test_reset();
      entry_t e;
      @(negedge clk);
      reset_n = 1'b0; op = 2'b01; funct_5 = 1'b0; funct_0 = 1'b0; mem_ready = 1'b1;
      e.ph = PF; e.o = 2'b01; e.f5 = 1'b0; e.f0 = 1'b0; e.cx = 1'b0; e.retire = 0;
      for (int r = 1; r >= 0; r--) begin
         mem_ready = 1'(r);
         e.rdy = 1'(r);
         #1;
         vectors++;
         if (obs_m !== exp_vec(e)) begin
            miscompares++;
            $display("FAIL reset_outputs rdy=%0d got %h want %h", r, obs_m, exp_vec(e));
         end
         vectors++;
         if (m_instr_count !== 32'd0 || a_instr_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_count got %0d/%0d want 0", m_instr_count, a_instr_count);
         end
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_directed();
      entry_t e;
      do_reset();
      build(15, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0);  // DP reg
      build(15, 2'b01, 1'b0, 1'b1, 1'b1, 0, 3);  // LDR, 3 wait cycles
      build(15, 2'b01, 1'b0, 1'b0, 1'b1, 0, 0);  // STR
      build(15, 2'b10, 1'b0, 1'b0, 1'b1, 0, 0);  // B
      build(15, 2'b00, 1'b1, 1'b0, 1'b0, 0, 0);  // DP skipped by condition
      build(15, 2'b11, 1'b0, 1'b0, 1'b1, 2, 0);  // undefined
      build(15, 2'b00, 1'b1, 1'b0, 1'b1, 15, 0); // DP imm, ready arrives at the limit
      build(15, 2'b01, 1'b0, 1'b0, 1'b1, 0, 15); // STR, ready arrives at the limit
      while (sched.size() > 0) begin
         e = sched.pop_front();
         apply(e);
         vectors++;
         if (obs_m !== exp_vec(e)) begin
            miscompares++;
            $display("FAIL directed_outputs phase=%s got %h want %h", e.ph.name(), obs_m,
                     exp_vec(e));
         end
         vectors++;
         if (m_instr_count !== 32'(cnt_m)) begin
            miscompares++;
            $display("FAIL directed_count got %0d want %0d", m_instr_count, cnt_m);
         end
         if (e.retire) cnt_m++;
      end
      @(negedge clk);
      vectors++;
      if (m_instr_count !== 32'd8) begin
         miscompares++;
         $display("FAIL directed_final_count got %0d want 8", m_instr_count);
      end
   endtask

   task automatic test_fault();
      entry_t e;
      do_reset();
      build(3, 2'b10, 1'b0, 1'b0, 1'b1, 100, 0);
      for (int i = 0; i < 6; i++) push(PFLT, rb(), rb(), 2'b10, 1'b0, 1'b0, 0);
      while (sched.size() > 0) begin
         e = sched.pop_front();
         apply(e);
         vectors++;
         if (obs_a !== exp_vec(e)) begin
            miscompares++;
            $display("FAIL fault_outputs phase=%s got %h want %h", e.ph.name(), obs_a,
                     exp_vec(e));
         end
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      e.ph = PF; e.rdy = mem_ready;
      vectors++;
      if (obs_a !== exp_vec(e)) begin
         miscompares++;
         $display("FAIL fault_cleared got %h want %h", obs_a, exp_vec(e));
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_wrap();
      entry_t e;
      do_reset();
      for (int i = 0; i < 17; i++) build(3, 2'b10, 1'b0, 1'b0, 1'b1, 0, 0);
      while (sched.size() > 0) begin
         e = sched.pop_front();
         apply(e);
         vectors++;
         if (obs_a !== exp_vec(e) || a_instr_count !== 4'(cnt_a % 16)) begin
            miscompares++;
            $display("FAIL wrap_cycle got %h/%0d want %h/%0d", obs_a, a_instr_count,
                     exp_vec(e), cnt_a % 16);
         end
         if (e.retire) cnt_a++;
      end
      @(negedge clk);
      vectors++;
      if (a_instr_count !== 4'd1) begin
         miscompares++;
         $display("FAIL wrap_final got %0d want 1", a_instr_count);
      end
   endtask

   task automatic test_reset_mid();
      entry_t e;
      bit hit = 0;
      do_reset();
      build(15, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0);
      build(15, 2'b01, 1'b0, 1'b1, 1'b1, 1, 5);
      while (sched.size() > 0 && !hit) begin
         e = sched.pop_front();
         apply(e);
         vectors++;
         if (obs_m !== exp_vec(e) || m_instr_count !== 32'(cnt_m)) begin
            miscompares++;
            $display("FAIL midreset_pre got %h/%0d want %h/%0d", obs_m, m_instr_count,
                     exp_vec(e), cnt_m);
         end
         if (e.retire) cnt_m++;
         if (e.ph == PMR && !e.rdy && sched.size() < 4) hit = 1;
      end
      #2 reset_n = 1'b0;
      #1;
      e.ph = PF; e.rdy = mem_ready;
      vectors++;
      if (obs_m !== exp_vec(e) || m_instr_count !== 32'd0) begin
         miscompares++;
         $display("FAIL midreset_async got %h/%0d want %h/0", obs_m, m_instr_count,
                  exp_vec(e));
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      cnt_m = 0;
      sched.delete();
      build(15, 2'b01, 1'b1, 1'b0, 1'b1, 0, 1);
      while (sched.size() > 0) begin
         e = sched.pop_front();
         apply(e);
         vectors++;
         if (obs_m !== exp_vec(e) || m_instr_count !== 32'(cnt_m)) begin
            miscompares++;
            $display("FAIL midreset_post got %h/%0d want %h/%0d", obs_m, m_instr_count,
                     exp_vec(e), cnt_m);
         end
         if (e.retire) cnt_m++;
      end
   endtask

   function automatic int pick_wait();
      int r = int'($urandom_range(0, 9));
      if (r < 6) return 0;
      if (r < 9) return int'($urandom_range(1, 4));
      return 15;
   endfunction

   task automatic test_random();
      entry_t e;
      do_reset();
      for (int i = 0; i < 60; i++)
         build(15, 2'($urandom), rb(), rb(), ($urandom_range(0, 3) != 0), pick_wait(),
               pick_wait());
      while (sched.size() > 0) begin
         e = sched.pop_front();
         apply(e);
         vectors++;
         if (obs_m !== exp_vec(e)) begin
            miscompares++;
            $display("FAIL random_outputs phase=%s op=%b got %h want %h", e.ph.name(), e.o,
                     obs_m, exp_vec(e));
         end
         vectors++;
         if (m_instr_count !== 32'(cnt_m)) begin
            miscompares++;
            $display("FAIL random_count got %0d want %0d", m_instr_count, cnt_m);
         end
         if (e.retire) cnt_m++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_fault();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
